// File: rtl/exec_stage.sv
// Execute stage: ALU, flags, branch resolution, memory-op decode and an optional
// multiplexed seven-segment display of the last OUT operand (EXEC_STAGE_DISPLAY_EN).
module exec_stage #(
  parameter int WIDTH    = 16,
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   alu_a,
  input  logic [WIDTH-1:0]   alu_b,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   dipswitch,
  input  logic               write_reg,
  input  logic [2:0]         reg_addr,
  input  logic [1:0]         mem_op,
  input  logic [WIDTH-1:0]   addr_in,
  input  logic [WIDTH-1:0]   store_in,
  input  logic               is_branch,
  input  logic [2:0]         cond,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_result,
  output logic               write_reg_o,
  output logic [2:0]         reg_addr_o,
  output logic [WIDTH-1:0]   addr_o,
  output logic [WIDTH-1:0]   store_o,
  output logic               rd_en,
  output logic               wr_en,
  output logic               pc_src,
  output logic [WIDTH-1:0]   pc_target,
  output logic [3:0]         flags,
  output logic               halt,
  output logic [7:0]         seg,
  output logic [NDIGITS-1:0] digit_sel
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_CMP = 4'd5,  OP_MOV = 4'd6,  OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9,  OP_SRL = 4'd10, OP_SRA = 4'd11, OP_IN  = 4'd12;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic                      accept;
  logic [SH_W-1:0]           sh;
  logic [WIDTH:0]            sum, diff;
  logic [2*WIDTH-1:0]        sll_w, srl_w;
  logic signed [2*WIDTH-1:0] sra_w;
  logic [WIDTH-1:0]          result;
  logic                      carry, ovf, upd_flags, taken;

  assign accept = in_valid & ~stall & ~flush;
  assign sh     = alu_b[SH_W-1:0];
  assign sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff   = {1'b0, alu_a} - {1'b0, alu_b};
  // Double-width shifts keep the last bit shifted out at a fixed position (0 when sh==0).
  assign sll_w  = {{WIDTH{1'b0}}, alu_a} << sh;
  assign srl_w  = {alu_a, {WIDTH{1'b0}}} >> sh;
  assign sra_w  = $signed({alu_a, {WIDTH{1'b0}}}) >>> sh;

  always_comb begin
    result    = alu_a;
    carry     = 1'b0;
    ovf       = 1'b0;
    upd_flags = 1'b1;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (result[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (result[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_AND: result = alu_a & alu_b;
      OP_OR:  result = alu_a | alu_b;
      OP_XOR: result = alu_a ^ alu_b;
      OP_MOV: result = alu_b;
      OP_SLL: begin
        result = sll_w[WIDTH-1:0];
        carry  = sll_w[WIDTH];
      end
      OP_SLR: begin
        result = sll_w[WIDTH-1:0] | sll_w[2*WIDTH-1:WIDTH];
        carry  = sll_w[WIDTH];
      end
      OP_SRL: begin
        result = srl_w[2*WIDTH-1:WIDTH];
        carry  = srl_w[WIDTH-1];
      end
      OP_SRA: begin
        result = sra_w[2*WIDTH-1:WIDTH];
        carry  = sra_w[WIDTH-1];
      end
      OP_IN: begin
        result    = dipswitch;
        upd_flags = 1'b0;
      end
      default: upd_flags = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0: taken = flags[2];
      3'd1: taken = flags[3] ^ flags[0];
      3'd2: taken = flags[2] | (flags[3] ^ flags[0]);
      3'd3: taken = ~flags[2];
      3'd4: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_result  <= '0;
      write_reg_o <= 1'b0;
      reg_addr_o  <= '0;
      addr_o      <= '0;
      store_o     <= '0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      pc_src      <= 1'b0;
      pc_target   <= '0;
      flags       <= '0;
      halt        <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid   <= 1'b0;
      write_reg_o <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      pc_src      <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_result  <= result;
      write_reg_o <= write_reg;
      reg_addr_o  <= reg_addr;
      addr_o      <= addr_in;
      store_o     <= store_in;
      rd_en       <= (mem_op == 2'd1);
      wr_en       <= (mem_op == 2'd2);
      pc_src      <= is_branch & taken;
      pc_target   <= is_branch ? store_in : '0;
      if (upd_flags) flags <= {result[WIDTH-1], (result == '0), carry, ovf};
      if (op == OP_HLT) halt <= 1'b1;
    end
  end

`ifdef EXEC_STAGE_DISPLAY_EN
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [WIDTH-1:0]     disp, disp_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [NDIGITS*4-1:0] pad;
  logic [3:0]           nib;
  logic [7:0]           seg_nx;

  // seg/digit_sel are registered from next-state values so they never lag the digit index.
  always_comb begin
    disp_nx = (accept && op == 4'd13) ? alu_a : disp;
    cnt_nx  = cnt + 1'b1;
    idx_nx  = idx;
    if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + 1'b1;
    end
    pad = '0;
    pad[WIDTH-1:0] = disp_nx;
    nib = '0;
    for (int unsigned d = 0; d < NDIGITS; d++)
      if (idx_nx == IDX_W'(d)) nib = pad[d*4 +: 4];
    case (nib)
      4'h0: seg_nx = 8'hFC;  4'h1: seg_nx = 8'h60;  4'h2: seg_nx = 8'hDA;  4'h3: seg_nx = 8'hF2;
      4'h4: seg_nx = 8'h66;  4'h5: seg_nx = 8'hB6;  4'h6: seg_nx = 8'hBE;  4'h7: seg_nx = 8'hE0;
      4'h8: seg_nx = 8'hFE;  4'h9: seg_nx = 8'hF6;  4'hA: seg_nx = 8'hEE;  4'hB: seg_nx = 8'h3E;
      4'hC: seg_nx = 8'h1A;  4'hD: seg_nx = 8'h7A;  4'hE: seg_nx = 8'h9E;  default: seg_nx = 8'h8E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp      <= '0;
      cnt       <= '0;
      idx       <= '0;
      seg       <= '0;
      digit_sel <= NDIGITS'(1);
    end else begin
      disp      <= disp_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      seg       <= seg_nx;
      digit_sel <= NDIGITS'(1) << idx_nx;
    end
  end
`else
  assign seg       = '0;
  assign digit_sel = '0;
`endif
endmodule

// File: tb/tb_exec_stage.sv
// Directed table-driven bench for exec_stage plus hand-written stall/flush/display/reset sequences.
module tb_exec_stage;
  localparam int W = 16;
`ifdef EXEC_STAGE_DISPLAY_EN
  localparam bit DISP = 1'b1;
`else
  localparam bit DISP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [W-1:0] alu_a = '0, alu_b = '0, dipswitch = '0, addr_in = '0, store_in = '0;
  logic [3:0] op = '0;
  logic write_reg = 1'b0, is_branch = 1'b0;
  logic [2:0] reg_addr = '0, cond = '0;
  logic [1:0] mem_op = '0;
  logic out_valid, write_reg_o, rd_en, wr_en, pc_src, halt;
  logic [W-1:0] alu_result, addr_o, store_o, pc_target;
  logic [2:0] reg_addr_o;
  logic [3:0] flags, digit_sel;
  logic [7:0] seg;

  int n_vec = 0;
  int n_bad = 0;

  exec_stage #(.WIDTH(16), .NDIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .op(op), .dipswitch(dipswitch),
    .write_reg(write_reg), .reg_addr(reg_addr), .mem_op(mem_op), .addr_in(addr_in),
    .store_in(store_in), .is_branch(is_branch), .cond(cond),
    .out_valid(out_valid), .alu_result(alu_result), .write_reg_o(write_reg_o),
    .reg_addr_o(reg_addr_o), .addr_o(addr_o), .store_o(store_o), .rd_en(rd_en),
    .wr_en(wr_en), .pc_src(pc_src), .pc_target(pc_target), .flags(flags),
    .halt(halt), .seg(seg), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, dip, store;
    logic [1:0]   mem_op;
    logic         br;
    logic [2:0]   cond;
    logic [W-1:0] res;
    logic [3:0]   flg;   // {S,Z,C,V}
    logic         psrc;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; alu_a = a; alu_b = b;
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] t[16];
    t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};
    return t[n];
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".alu_result"}, 32'(alu_result), 0);
    chk({tag, ".write_reg_o"}, 32'(write_reg_o), 0);
    chk({tag, ".rd_wr"}, 32'({rd_en, wr_en}), 0);
    chk({tag, ".pc_src"}, 32'(pc_src), 0);
    chk({tag, ".pc_target"}, 32'(pc_target), 0);
    chk({tag, ".flags"}, 32'(flags), 0);
    chk({tag, ".halt"}, 32'(halt), 0);
    chk({tag, ".seg"}, 32'(seg), 0);
    chk({tag, ".digit_sel"}, 32'(digit_sel), DISP ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [W-1:0] disp_val;
    logic [3:0]   nib;
    //          op     a        b        dip      store    mem br cond res      flg      psrc
    tbl[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h0, 16'h5678, 2'd0, 0, 3'd0, 16'h8000, 4'b1001, 0};
    tbl[1]  = '{4'd1,  16'h0005, 16'h0005, 16'h0, 16'h0011, 2'd1, 0, 3'd0, 16'h0000, 4'b0100, 0};
    tbl[2]  = '{4'd2,  16'hF0F0, 16'h3C3C, 16'h0, 16'h0022, 2'd2, 0, 3'd0, 16'h3030, 4'b0000, 0};
    tbl[3]  = '{4'd3,  16'h0F00, 16'h00F0, 16'h0, 16'h0033, 2'd3, 0, 3'd0, 16'h0FF0, 4'b0000, 0};
    tbl[4]  = '{4'd4,  16'hFFFF, 16'h00FF, 16'h0, 16'h0044, 2'd0, 0, 3'd0, 16'hFF00, 4'b1000, 0};
    tbl[5]  = '{4'd6,  16'h0000, 16'hABCD, 16'h0, 16'h0055, 2'd0, 0, 3'd0, 16'hABCD, 4'b1000, 0};
    tbl[6]  = '{4'd8,  16'h8001, 16'h0001, 16'h0, 16'h0066, 2'd0, 0, 3'd0, 16'h0002, 4'b0010, 0};
    tbl[7]  = '{4'd10, 16'h0003, 16'h0001, 16'h0, 16'h0077, 2'd0, 0, 3'd0, 16'h0001, 4'b0010, 0};
    tbl[8]  = '{4'd11, 16'h8001, 16'h0001, 16'h0, 16'h0088, 2'd0, 0, 3'd0, 16'hC000, 4'b1010, 0};
    tbl[9]  = '{4'd9,  16'h8001, 16'h0004, 16'h0, 16'h0099, 2'd0, 0, 3'd0, 16'h0018, 4'b0000, 0};
    tbl[10] = '{4'd8,  16'h1234, 16'hFFF0, 16'h0, 16'h00AA, 2'd0, 0, 3'd0, 16'h1234, 4'b0000, 0};
    tbl[11] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0, 16'h00BB, 2'd0, 0, 3'd0, 16'h0000, 4'b0110, 0};
    tbl[12] = '{4'd12, 16'h0000, 16'h0000, 16'hBEEF, 16'h00CC, 2'd0, 0, 3'd0, 16'hBEEF, 4'b0110, 0};
    tbl[13] = '{4'd5,  16'h0003, 16'h0005, 16'h0, 16'h00DD, 2'd0, 0, 3'd0, 16'hFFFE, 4'b1010, 0};
    tbl[14] = '{4'd14, 16'h0000, 16'h0000, 16'h0, 16'h0040, 2'd0, 1, 3'd1, 16'h0000, 4'b1010, 1};
    tbl[15] = '{4'd14, 16'h0000, 16'h0000, 16'h0, 16'h0080, 2'd0, 1, 3'd0, 16'h0000, 4'b1010, 0};
    tbl[16] = '{4'd7,  16'h5555, 16'h0000, 16'h0, 16'h0090, 2'd0, 1, 3'd3, 16'h5555, 4'b1010, 1};
    tbl[17] = '{4'd1,  16'h8000, 16'h0001, 16'h0, 16'h00A0, 2'd0, 1, 3'd5, 16'h7FFF, 4'b0001, 0};
    tbl[18] = '{4'd14, 16'h1111, 16'h0000, 16'h0, 16'h00B0, 2'd0, 1, 3'd2, 16'h1111, 4'b0001, 1};
    tbl[19] = '{4'd14, 16'h4321, 16'h0000, 16'h0, 16'h00C0, 2'd0, 1, 3'd4, 16'h4321, 4'b0001, 1};

    // Reset with garbage stimulus present.
    drive(4'd0, 16'h1111, 16'h2222); stall = 1'b1; flush = 1'b1;
    repeat (3) tick();
    chk_reset_state("reset");

    // OUT 12AB on the very first edge after reset, then watch the scanner (SCAN_DIV=4).
    stall = 1'b0; flush = 1'b0;
    drive(4'd13, 16'h12AB, 16'h0000);
    rst_n = 1'b1;
    disp_val = 16'h12AB;
    for (int k = 1; k <= 16; k++) begin
      tick();
      in_valid = 1'b0;
      if (k == 1) chk("out.alu_result", 32'(alu_result), 32'h12AB);
      nib = disp_val[((k / 4) % 4) * 4 +: 4];
      chk($sformatf("scan%0d.digit_sel", k), 32'(digit_sel), DISP ? 32'(4'b0001 << ((k / 4) % 4)) : 0);
      chk($sformatf("scan%0d.seg", k), 32'(seg), DISP ? 32'(enc(nib)) : 0);
    end
    chk("out.flags_untouched", 32'(flags), 0);

    // Back-to-back table vectors; branch conditions use flags left by the previous row.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      dipswitch = tbl[i].dip; store_in = tbl[i].store; mem_op = tbl[i].mem_op;
      is_branch = tbl[i].br; cond = tbl[i].cond;
      write_reg = i[0]; reg_addr = 3'(i); addr_in = 16'h1000 + 16'(i);
      tick();
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d.alu_result", i), 32'(alu_result), 32'(tbl[i].res));
      chk($sformatf("v%0d.flags", i), 32'(flags), 32'(tbl[i].flg));
      chk($sformatf("v%0d.pc_src", i), 32'(pc_src), 32'(tbl[i].psrc));
      chk($sformatf("v%0d.pc_target", i), 32'(pc_target), tbl[i].br ? 32'(tbl[i].store) : 0);
      chk($sformatf("v%0d.rd_wr", i), 32'({rd_en, wr_en}),
          32'({tbl[i].mem_op == 2'd1, tbl[i].mem_op == 2'd2}));
      chk($sformatf("v%0d.wreg", i), 32'({write_reg_o, reg_addr_o}), 32'({i[0], 3'(i)}));
      chk($sformatf("v%0d.addr_store", i), 32'({addr_o, store_o}),
          32'({16'h1000 + 16'(i), tbl[i].store}));
    end

    // Idle: control outputs drop, data holds, taken branch lasted one cycle.
    in_valid = 1'b0; is_branch = 1'b0; mem_op = 2'd0;
    tick();
    chk("idle.out_valid", 32'(out_valid), 0);
    chk("idle.pc_src", 32'(pc_src), 0);
    chk("idle.write_reg_o", 32'(write_reg_o), 0);
    chk("idle.alu_result", 32'(alu_result), 32'h4321);

    // Valid ADD held by stall for three cycles.
    drive(4'd0, 16'h0001, 16'h0001); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d.out_valid", k), 32'(out_valid), 0);
      chk($sformatf("stall%0d.alu_result", k), 32'(alu_result), 32'h4321);
      chk($sformatf("stall%0d.flags", k), 32'(flags), 32'b0001);
    end
    stall = 1'b0;
    tick();
    chk("unstall.alu_result", 32'(alu_result), 32'h0002);
    chk("unstall.flags", 32'(flags), 0);
    drive(4'd0, 16'h7FFF, 16'h0001); stall = 1'b1;
    tick();
    chk("stall_hold.out_valid", 32'(out_valid), 1);
    chk("stall_hold.alu_result", 32'(alu_result), 32'h0002);
    flush = 1'b1;
    tick();
    chk("stall_flush.out_valid", 32'(out_valid), 0);
    chk("stall_flush.flags", 32'(flags), 0);
    chk("stall_flush.alu_result", 32'(alu_result), 32'h0002);
    stall = 1'b0; flush = 1'b0;

    // Halt is sticky, later accepts still execute, reset mid-stall clears everything.
    drive(4'd15, 16'h0042, 16'h0000);
    tick();
    chk("hlt.halt", 32'(halt), 1);
    chk("hlt.alu_result", 32'(alu_result), 32'h0042);
    drive(4'd0, 16'h0001, 16'h0002);
    tick();
    chk("post_hlt.alu_result", 32'(alu_result), 32'h0003);
    chk("post_hlt.halt", 32'(halt), 1);
    stall = 1'b1;
    tick();
    chk("hlt_stall.halt", 32'(halt), 1);
    rst_n = 1'b0;
    tick();
    chk_reset_state("hlt_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (>=8, multiple of 4).
REQ-002 SHALL have parameter NDIGITS, default 4, number of seven-segment digits (NDIGITS*4 >= WIDTH).
REQ-003 SHALL have parameter SCAN_DIV, default 1024, clk cycles each digit is driven (>=2).
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 synchronous active-low reset; one clock, all state on rising clk edge.
REQ-005 SHALL have ports: in_valid in 1 instruction present; stall in 1 hold stage; flush in 1 kill stage contents.
REQ-006 SHALL have ports: alu_a in WIDTH operand A; alu_b in WIDTH operand B; op in 4 opcode; dipswitch in WIDTH IN source.
REQ-007 SHALL have ports: write_reg in 1; reg_addr in 3; mem_op in 2 (1=read, 2=write, else none); addr_in in WIDTH; store_in in WIDTH; is_branch in 1; cond in 3.
REQ-008 SHALL have ports: out_valid out 1; alu_result out WIDTH; write_reg_o out 1; reg_addr_o out 3; addr_o out WIDTH; store_o out WIDTH; rd_en out 1; wr_en out 1.
REQ-009 SHALL have ports: pc_src out 1 branch taken; pc_target out WIDTH; flags out 4 {S,Z,C,V}; halt out 1; seg out 8 segments a..g,dp bits 7..0 active-high; digit_sel out NDIGITS one-hot active-high.

Function
REQ-010 Accept = in_valid & ~stall & ~flush; all outputs registered, latency 1 cycle from accept.
REQ-011 On accept: out_valid<=1; alu_result, write_reg_o, reg_addr_o, addr_o, store_o load from inputs/ALU; rd_en<=(mem_op==1); wr_en<=(mem_op==2).
REQ-012 Cycle with stall=1, flush=0: every output and internal register holds, except display scanner.
REQ-013 Cycle with flush=1 (priority over stall): out_valid, write_reg_o, rd_en, wr_en, pc_src <=0; flags, halt, display register unchanged.
REQ-014 Cycle with in_valid=0, stall=0, flush=0: out_valid, write_reg_o, rd_en, wr_en, pc_src <=0; data outputs hold.
REQ-015 ALU ops: 0 ADD, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 CMP (a-b), 6 MOV (b), 8 SLL, 9 SLR rotate-left, 10 SRL, 11 SRA, 12 IN (dipswitch), 13 OUT (a), 14 NOP (a), 15 HLT (a); 7 treated as NOP.
REQ-016 Shift amount = alu_b[log2(WIDTH)-1:0]; results truncated to WIDTH, wrap modulo 2^WIDTH.
REQ-017 Flags update only on accept of ops 0-11: S=result msb; Z=(result==0); V=signed overflow for 0,1,5 else 0; C=carry-out for ADD, borrow (a<b unsigned) for SUB/CMP, last bit shifted out for 8-11 (0 when amount 0), 0 for others.
REQ-018 Branch on accept with is_branch=1, evaluated on flags register before this instruction's update: cond 0 Z; 1 S^V; 2 Z|(S^V); 3 ~Z; 4 1; 5-7 0.
REQ-019 pc_src registered, high exactly one cycle per taken branch; pc_target<=store_in when is_branch accepted, else 0.
REQ-020 Accept of op 15 sets halt, sticky until reset; subsequent accepts still processed.
REQ-021 Accept of op 13 loads alu_a into display register.
REQ-022 Scanner: counter 0..SCAN_DIV-1; on wrap advance digit index 0..NDIGITS-1, wrap to 0; digit 0 = display bits [3:0]; nibbles above WIDTH show 0.
REQ-023 seg encoding: 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,8=FE,9=F6,A=EE,B=3E,C=1A,D=7A,E=9E,F=8E (hex); seg and digit_sel registered.

Reset
REQ-024 rst_n=0 at clk edge: all outputs 0 except digit_sel=1 (digit 0); flags=0, halt=0, display register 0, scanner counter 0; reset overrides stall, flush and in-flight instruction.
REQ-025 First accept possible on first edge with rst_n=1.

Configuration
REQ-026 Macro EXEC_STAGE_DISPLAY_EN defined: display register, scanner, seg/digit_sel logic per REQ-021..023.
REQ-027 Macro EXEC_STAGE_DISPLAY_EN undefined: no display logic; seg=0, digit_sel=0 constant; OUT behaves as NOP in ALU path.

Verification
REQ-028 ADD a=7FFF b=0001 -> next cycle alu_result=8000, flags S=1 Z=0 C=0 V=1.
REQ-029 CMP a=0003 b=0005 then branch cond=1 store_in=0040 -> pc_src=1 one cycle, pc_target=0040; cond=0 -> pc_src=0.
REQ-030 Valid ADD with stall=1 three cycles -> outputs/flags unchanged; stall+flush together -> out_valid=0, flags held.
REQ-031 SRA a=8001 b=0001 -> alu_result=C000, C=1; SLR a=8001 b=0004 -> 0018.
REQ-032 OUT a=12AB, SCAN_DIV=4 -> digit_sel 0001 seg=3E, 4 cycles later 0010 seg=EE, then 2 seg=DA, then 1 seg=60, wrap to 0001.
REQ-033 HLT accept then rst_n=0 mid-stall -> halt=1 until reset edge, then all outputs 0, digit_sel=0001.
